// File: rtl/dma_stream_arbiter_pkg.sv
// Shared width constant, arbiter state type and the round-robin search helper
// used by the DMA stream arbiter.
package dma_stream_arbiter_pkg;

    localparam int DMA_DATA_W = 128;
    localparam int RR_MAX     = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // First set bit of req, searching upward from ptr+1 and wrapping at n.
    function automatic logic [2:0] rr_first_set(
        input logic [RR_MAX-1:0] req,
        input logic [2:0]        ptr,
        input int                n
    );
        logic [2:0] pick;
        logic       found;
        int         idx;
        pick  = ptr;
        found = 1'b0;
        for (int k = 1; k <= RR_MAX; k++) begin
            idx = int'(ptr) + k;
            if (idx >= n) idx = idx - n;
            if (!found && k <= n && req[idx[2:0]]) begin
                pick  = idx[2:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/dma_stream_arbiter_skid.sv
// axis_skid_buffer: two-entry (main + skid) register slice, 1-cycle latency.
// in_rdy is a flop driven only by occupancy, so out_rdy never reaches the input side.
module axis_skid_buffer #(
    parameter int W = 129
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_vld,
    input  logic [W-1:0] in_dat,
    output logic         in_rdy,
    output logic         out_vld,
    output logic [W-1:0] out_dat,
    input  logic         out_rdy
);

    logic         out_vld_q, out_vld_d;
    logic [W-1:0] out_dat_q, out_dat_d;
    logic         skid_vld_q, skid_vld_d;
    logic [W-1:0] skid_dat_q, skid_dat_d;
    logic         in_rdy_q, in_rdy_d;
    logic         in_fire;

    always_comb begin
        in_fire    = in_vld & in_rdy_q;
        out_vld_d  = out_vld_q;
        out_dat_d  = out_dat_q;
        skid_vld_d = skid_vld_q;
        skid_dat_d = skid_dat_q;
        if (!out_vld_q || out_rdy) begin
            // Output slot frees up: a parked skid beat always goes first.
            if (skid_vld_q) begin
                out_vld_d  = 1'b1;
                out_dat_d  = skid_dat_q;
                skid_vld_d = 1'b0;
            end else begin
                out_vld_d = in_fire;
                if (in_fire) out_dat_d = in_dat;
            end
        end else if (in_fire) begin
            skid_vld_d = 1'b1;
            skid_dat_d = in_dat;
        end
        in_rdy_d = ~skid_vld_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q  <= 1'b0;
            out_dat_q  <= '0;
            skid_vld_q <= 1'b0;
            skid_dat_q <= '0;
            in_rdy_q   <= 1'b1;
        end else begin
            out_vld_q  <= out_vld_d;
            out_dat_q  <= out_dat_d;
            skid_vld_q <= skid_vld_d;
            skid_dat_q <= skid_dat_d;
            in_rdy_q   <= in_rdy_d;
        end
    end

    assign in_rdy  = in_rdy_q;
    assign out_vld = out_vld_q;
    assign out_dat = out_dat_q;

endmodule

// File: rtl/dma_stream_arbiter.sv
// Packet-level round-robin arbiter of NUM_SRC streams onto one DMA stream.
// Latency: 1 arbitration cycle per packet, 1 cycle data; backpressure via registered skid stage.
module dma_stream_arbiter
    import dma_stream_arbiter_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = DMA_DATA_W,
    parameter int SRC_W   = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC-1:0]        src_enable,
    input  logic [NUM_SRC*DATA_W-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]        s_axis_tlast,
    input  logic [NUM_SRC-1:0]        s_axis_tvalid,
    output logic [NUM_SRC-1:0]        s_axis_tready,
    output logic [DATA_W-1:0]         m_axis_dma_tdata,
    output logic                      m_axis_dma_tlast,
    output logic                      m_axis_dma_tvalid,
    input  logic                      m_axis_dma_tready,
    output logic                      busy,
    output logic [SRC_W-1:0]          grant_idx,
    output logic [31:0]               pkt_count
);

    arb_state_e        state_q, state_d;
    logic [SRC_W-1:0]  ptr_q, ptr_d;
    logic [SRC_W-1:0]  grant_q, grant_d;
    logic [31:0]       pkt_cnt_q, pkt_cnt_d;
    logic [RR_MAX-1:0] req_vec;
    logic [2:0]        rr_pick;
    logic              skid_in_vld, skid_in_rdy, skid_out_vld;
    logic [DATA_W:0]   skid_in_dat, skid_out_dat;
    logic              beat_fire;

    always_comb begin
        req_vec              = '0;
        req_vec[NUM_SRC-1:0] = s_axis_tvalid & src_enable;
        rr_pick              = rr_first_set(req_vec, 3'(ptr_q), NUM_SRC);
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_d       = grant_q;
        s_axis_tready = '0;
        skid_in_vld   = 1'b0;
        skid_in_dat   = {s_axis_tlast[grant_q], s_axis_tdata[int'(grant_q)*DATA_W +: DATA_W]};
        beat_fire     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req_vec) begin
                    grant_d = SRC_W'(rr_pick);
                    ptr_d   = SRC_W'(rr_pick);
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // Grant is held until tlast, however long the source stalls.
                s_axis_tready[grant_q] = skid_in_rdy;
                skid_in_vld            = s_axis_tvalid[grant_q];
                beat_fire              = skid_in_vld & skid_in_rdy;
                if (beat_fire && s_axis_tlast[grant_q]) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if (skid_out_vld && m_axis_dma_tready && skid_out_dat[DATA_W]) pkt_cnt_d = pkt_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= SRC_W'(NUM_SRC - 1);
            grant_q   <= '0;
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    axis_skid_buffer #(
        .W (DATA_W + 1)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (skid_in_vld),
        .in_dat  (skid_in_dat),
        .in_rdy  (skid_in_rdy),
        .out_vld (skid_out_vld),
        .out_dat (skid_out_dat),
        .out_rdy (m_axis_dma_tready)
    );

    assign m_axis_dma_tvalid = skid_out_vld;
    assign m_axis_dma_tlast  = skid_out_dat[DATA_W];
    assign m_axis_dma_tdata  = skid_out_dat[DATA_W-1:0];
    assign busy              = (state_q == ST_GRANT) | skid_out_vld;
    assign grant_idx         = grant_q;
    assign pkt_count         = pkt_cnt_q;

endmodule

// File: tb/tb_dma_stream_arbiter.sv
// Directed + randomized bench for dma_stream_arbiter with a packet-level round-robin model.
module tb_dma_stream_arbiter;

    localparam int N  = 4;
    localparam int DW = 128;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    src_enable;
    logic [N*DW-1:0] s_tdata;
    logic [N-1:0]    s_tlast, s_tvalid, s_tready;
    logic [DW-1:0]   m_tdata;
    logic            m_tlast, m_tvalid, m_tready, busy;
    logic [1:0]      grant_idx;
    logic [31:0]     pkt_count;

    dma_stream_arbiter #(.NUM_SRC(N), .DATA_W(DW), .SRC_W(2)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .src_enable        (src_enable),
        .s_axis_tdata      (s_tdata),
        .s_axis_tlast      (s_tlast),
        .s_axis_tvalid     (s_tvalid),
        .s_axis_tready     (s_tready),
        .m_axis_dma_tdata  (m_tdata),
        .m_axis_dma_tlast  (m_tlast),
        .m_axis_dma_tvalid (m_tvalid),
        .m_axis_dma_tready (m_tready),
        .busy              (busy),
        .grant_idx         (grant_idx),
        .pkt_count         (pkt_count)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    beat_t  src_q[N][$];
    beat_t  exp_q[$];
    int     grant_log[$];
    logic [N-1:0] src_mid;
    int     pkts_started[N];
    int     rr_last, out_beats, out_first, out_last, cyc, gap_pct, rdy_pct;
    logic   prev_stall;
    logic [DW:0] prev_dat;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Next packet owner: first enabled source with queued packets after the last grant.
    function automatic int model_next();
        for (int k = 1; k <= N; k++) begin
            int s;
            s = (rr_last + k) % N;
            if (src_enable[s] && src_q[s].size() > 0) return s;
        end
        return -1;
    endfunction

    task automatic add_pkt(input int s, input int len, input bit rnd, input int base);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = rnd ? {$urandom, $urandom, $urandom, $urandom} : 128'(base + i);
            b.last = (i == len - 1);
            src_q[s].push_back(b);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int s = 0; s < N; s++) begin
            src_q[s].delete();
            pkts_started[s] = 0;
        end
        exp_q.delete();
        grant_log.delete();
        src_mid = '0; s_tvalid = '0; s_tlast = '0;
        rr_last = N - 1; out_beats = 0; prev_stall = 1'b0;
        #1;
        chk("reset m_tvalid", m_tvalid, 0);
        chk("reset m_tlast", m_tlast, 0);
        chk("reset m_tdata", m_tdata, 0);
        chk("reset s_tready", s_tready, 0);
        chk("reset busy", busy, 0);
        chk("reset grant_idx", grant_idx, 0);
        chk("reset pkt_count", pkt_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One cycle: drive at the negedge, then sample and predict the coming posedge.
    task automatic cycle();
        beat_t b, e;
        int    nxt;
        for (int s = 0; s < N; s++) begin
            if (src_q[s].size() > 0) begin
                s_tvalid[s] = src_mid[s] ? ($urandom_range(99) >= gap_pct) : 1'b1;
                s_tdata[s*DW +: DW] = src_q[s][0].data;
                s_tlast[s] = src_q[s][0].last;
            end else begin
                s_tvalid[s] = 1'b0;
                s_tlast[s]  = 1'b0;
            end
        end
        m_tready = ($urandom_range(99) < rdy_pct);
        #1;
        chk("tready onehot", $countones(s_tready) <= 1, 1);
        if (prev_stall) begin
            chk("hold tvalid", m_tvalid, 1);
            chk("hold data", {m_tlast, m_tdata}, prev_dat);
        end
        if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) chk("unexpected out beat", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("out beat", {m_tlast, m_tdata}, e);
            end
            if (out_beats == 0) out_first = cyc;
            out_last = cyc;
            out_beats++;
        end
        prev_stall = m_tvalid & ~m_tready;
        prev_dat   = {m_tlast, m_tdata};
        for (int s = 0; s < N; s++) begin
            if (s_tvalid[s] && s_tready[s]) begin
                if (!src_mid[s]) begin
                    nxt = model_next();
                    chk("grant order", s, nxt);
                    chk("grant_idx", grant_idx, s);
                    chk("no interleave", src_mid, 0);
                    rr_last = s;
                    grant_log.push_back(s);
                    pkts_started[s]++;
                    foreach (src_q[s][i]) begin
                        exp_q.push_back(src_q[s][i]);
                        if (src_q[s][i].last) break;
                    end
                end
                b = src_q[s].pop_front();
                src_mid[s] = ~b.last;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_until(input string tag, input int beats, input int budget);
        int n;
        n = 0;
        while (out_beats < beats && n < budget) begin
            cycle();
            n++;
        end
        repeat (6) cycle();
        chk({tag, " beat total"}, out_beats, beats);
    endtask

    initial begin
        int t0, tot, n;
        bit cleared;
        rst_n = 1'b1; src_enable = '1; m_tready = 1'b0;
        s_tvalid = '0; s_tlast = '0; s_tdata = '0;
        gap_pct = 0; rdy_pct = 100; cyc = 0;
        @(negedge clk);
        do_reset();

        // Single 4-beat packet from source 0, data 0..3.
        add_pkt(0, 4, 1'b0, 0);
        t0 = cyc;
        run_until("single", 4, 40);
        chk("first valid latency", out_first - t0, 2);
        chk("burst span", out_last - out_first, 3);
        chk("pkt_count single", pkt_count, 1);
        chk("busy after drain", busy, 0);

        // All sources offer two 2-beat packets each.
        do_reset();
        for (int p = 0; p < 2; p++)
            for (int s = 0; s < N; s++) add_pkt(s, 2, 1'b0, s * 256 + p * 16);
        run_until("all rr", 16, 200);
        chk("pkt_count rr", pkt_count, 8);
        chk("rr first", grant_log[0], 0);
        chk("rr fifth", grant_log[4], 0);

        // Enable mask 1010, then drop source 1 during its second packet.
        do_reset();
        src_enable = 4'b1010;
        for (int s = 0; s < N; s++)
            for (int p = 0; p < 3; p++) add_pkt(s, 2, 1'b0, s * 256 + p * 16);
        cleared = 1'b0; n = 0;
        while (out_beats < 10 && n < 200) begin
            cycle();
            n++;
            if (!cleared && pkts_started[1] == 2 && src_mid[1]) begin
                src_enable[1] = 1'b0;
                cleared = 1'b1;
            end
        end
        repeat (6) cycle();
        chk("mask beat total", out_beats, 10);
        chk("mask pkt_count", pkt_count, 5);
        chk("mask src1 pkts", pkts_started[1], 2);
        chk("mask src3 pkts", pkts_started[3], 3);
        chk("mask src0 pkts", pkts_started[0], 0);
        src_enable = '1;

        // 16-beat packet against 50% downstream ready.
        do_reset();
        rdy_pct = 50;
        add_pkt(1, 16, 1'b1, 0);
        run_until("stall", 16, 400);
        chk("stall pkt_count", pkt_count, 1);
        chk("stall busy", busy, 0);

        // Random packets on all sources with source gaps and downstream stalls.
        do_reset();
        rdy_pct = 70; gap_pct = 20; tot = 0;
        for (int p = 0; p < 3; p++)
            for (int s = 0; s < N; s++) begin
                n = $urandom_range(6, 1);
                tot += n;
                add_pkt(s, n, 1'b1, 0);
            end
        run_until("random", tot, 1500);
        chk("random pkt_count", pkt_count, 12);

        // Reset during beat 3 of a 6-beat packet.
        do_reset();
        rdy_pct = 100; gap_pct = 0; n = 0;
        add_pkt(2, 6, 1'b1, 0);
        while (src_q[2].size() > 3 && n < 40) begin
            cycle();
            n++;
        end
        chk("beat3 in flight", m_tvalid, 1);
        chk("busy mid packet", busy, 1);
        do_reset();
        add_pkt(3, 2, 1'b1, 0);
        add_pkt(2, 2, 1'b1, 0);
        add_pkt(0, 2, 1'b1, 0);
        run_until("post reset", 6, 100);
        chk("first grant after reset", grant_log[0], 0);
        chk("post reset pkt_count", pkt_count, 3);

        // Counter wrap.
        do_reset();
        rdy_pct = 0;
        add_pkt(0, 1, 1'b0, 165);
        repeat (4) cycle();
        chk("parked beat", m_tvalid, 1);
        force dut.pkt_cnt_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.pkt_cnt_q;
        #1;
        chk("preload", pkt_count, 32'hFFFF_FFFF);
        prev_stall = 1'b0;
        rdy_pct = 100;
        run_until("wrap", 1, 20);
        chk("pkt_count wrap", pkt_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dma_stream_arbiter.md
Name: dma_stream_arbiter

Overview:
- Packet-level round-robin arbiter that shares the single 128-bit DMA AXI-Stream towards PCIe among NUM_SRC producers (per-port capture/statistics engines inside the reconfigurable partition).
- Once a source is granted, its whole packet passes through before another source is considered.
- Output goes through a registered skid stage, giving full throughput and timing isolation from the PCIe DMA engine.

Parameters:
- NUM_SRC, 4, number of requesting streams (2..8).
- DATA_W, 128, tdata width in bits.
- SRC_W, 2, width of grant index; must satisfy 2**SRC_W >= NUM_SRC.

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous active-low reset.
- src_enable  in  NUM_SRC  per-source arbitration enable; sampled only at arbitration.
- s_axis_tdata  in  NUM_SRC*DATA_W  source data, source i at bits [i*DATA_W +: DATA_W].
- s_axis_tlast  in  NUM_SRC  per-source end of packet.
- s_axis_tvalid  in  NUM_SRC  per-source valid.
- s_axis_tready  out  NUM_SRC  per-source ready; at most one bit high.
- m_axis_dma_tdata  out  DATA_W  arbitrated data.
- m_axis_dma_tlast  out  1  arbitrated end of packet.
- m_axis_dma_tvalid  out  1  arbitrated valid.
- m_axis_dma_tready  in  1  downstream ready.
- busy  out  1  high while a packet is granted or output beats are pending.
- grant_idx  out  SRC_W  index of the current or last granted source.
- pkt_count  out  32  packets completed on the output (tlast beats accepted downstream); wraps.

Behaviour:
- Reset values: m_axis_dma_tvalid=0, tlast=0, tdata=0, s_axis_tready=0, busy=0, grant_idx=0, pkt_count=0, RR pointer=NUM_SRC-1, so source 0 has first priority.
- FSM states:
  - IDLE: req = s_axis_tvalid & src_enable. If req is nonzero, choose the first set bit searching from pointer+1 upward with wrap. Register grant_idx, set pointer=grant, go to GRANT. Otherwise stay in IDLE. No tready is asserted in IDLE.
  - GRANT: s_axis_tready[grant_idx] = skid stage can accept; all other bits are 0. A beat transfers when tvalid and tready are both high on the granted source. A transferred beat with tlast=1 returns the FSM to IDLE in the next cycle.
- Latency:
  - 1 arbitration cycle per packet, so a bubble of exactly one input cycle between packets.
  - Data latency is 1 cycle from source handshake to m_axis_dma_tvalid.
- Skid stage:
  - 2-entry buffer (main plus skid register).
  - Input ready is registered and depends only on buffer occupancy, never combinationally on m_axis_dma_tready.
  - Sustains 1 beat/cycle with tready held high.
  - Holds data stable while tvalid=1 and tready=0.
  - m_axis_dma_tvalid never drops without a handshake.
- src_enable deasserted for the granted source mid-packet: the packet completes normally; the source is excluded from the next arbitration.
- Granted source drops tvalid mid-packet: the grant is held indefinitely (no timeout, no truncation).
- Only one requester: it is re-granted after each packet, with the one-cycle bubble.
- pkt_count increments on each accepted output beat with tlast=1; it wraps from 0xFFFFFFFF to 0.
- busy = (state==GRANT) | m_axis_dma_tvalid.
- Reset asserted mid-packet: immediate clear of FSM, pointer, buffer and counter. The partial packet is discarded; no tlast is emitted for it. The upstream sources are reset by the same rst_n.

Decomposition:
- Shared package holds:
  - the DMA stream width constant (128);
  - a FSM state typedef (IDLE, GRANT);
  - a function for round-robin first-set-bit search from an offset.
- Natural sub-module: axis_skid_buffer (DATA_W+1 wide, registered ready), reused by other stream blocks.

Test Plan:
- Source 0 sends a 4-beat packet with tdata 0x0..0x3, m_axis_dma_tready=1.
  - Output tvalid first high 2 cycles after s_axis_tvalid (1 arbitration + 1 data latency).
  - 4 consecutive beats; tlast only on beat 4; pkt_count=1.
- All 4 sources continuously offer 2-beat packets.
  - Grant order 0,1,2,3,0,1…; no interleaving of beats within a packet.
  - After 8 packets, pkt_count=8.
- src_enable=4'b1010 with all sources valid → only sources 1 and 3 are granted, alternating. Clear bit 1 during source 1's packet → the packet finishes intact, then source 3 only.
- Random m_axis_dma_tready (50%) over a 16-beat packet.
  - Output data is stable while stalled.
  - No beat is lost or duplicated; throughput is 1 beat/cycle when tready=1.
- rst_n pulsed low during beat 3 of a 6-beat packet.
  - All outputs are at reset values asynchronously.
  - After release, the next grant goes to source 0 first; pkt_count=0.
- pkt_count preloaded by force to 0xFFFFFFFF, then one packet completes → pkt_count=0.
